// File: rtl/ram_nav_ctrl.sv
// ram_nav_ctrl: button-driven browse/edit controller around an inferred
// single-port synchronous RAM. A wrap-around pointer walks the RAM in
// STEP-sized jumps; in edit mode a write press stores wdata at the pointer.
// Optional feature macro: AUTO_REPEAT_EN enables auto-repeat of a held
// next/prev button (HOLD_CYC before the first repeat, then every RPT_CYC).
module ram_nav_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32768,
  parameter int ADDR_W   = 15,
  parameter int STEP     = 1,
  parameter int HOLD_CYC = 50000000,
  parameter int RPT_CYC  = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch,
  input  logic [2:0]        btn,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic              wr_ack
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] STEP_P  = PW'(STEP);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]  btn_s1, btn_s2, hist, ev, rise, evt_next;
  logic        sw_s1, sw_s2;
  // vld marks when btn_s2 holds a real post-reset sample; until then hist
  // stays all-ones so a button held through reset never looks like a rise.
  logic [1:0]  vld;
  logic        do_next, do_prev, do_wr;
  logic [PW-1:0]     addr_ext, sum;
  logic [ADDR_W-1:0] next_addr, prev_addr;

  // Two-flop synchronisers for buttons and mode switch, plus edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 3'b000;
      btn_s2 <= 3'b000;
      sw_s1  <= 1'b0;
      sw_s2  <= 1'b0;
      hist   <= 3'b111;
      vld    <= 2'b00;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      sw_s1  <= switch;
      sw_s2  <= sw_s1;
      vld    <= {vld[0], 1'b1};
      if (vld[1]) hist <= btn_s2;
    end
  end

  assign rise = btn_s2 & ~hist;

`ifdef AUTO_REPEAT_EN
  logic [31:0] rpt_cnt [2];
  logic [1:0]  armed;
  logic [1:0]  rpt_hit;

  // A repeat fires when an armed, still-held button's down-counter is at zero
  always_comb begin
    rpt_hit = 2'b00;
    for (int i = 0; i < 2; i++)
      rpt_hit[i] = armed[i] & btn_s2[i] & (rpt_cnt[i] == 32'd0);
  end

  // Per-button repeat timers: load HOLD on the edge event, reload RPT on each repeat
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 2'b00;
      for (int i = 0; i < 2; i++) rpt_cnt[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!btn_s2[i]) begin
          armed[i]   <= 1'b0;
          rpt_cnt[i] <= 32'd0;
        end else if (rise[i]) begin
          armed[i]   <= 1'b1;
          rpt_cnt[i] <= 32'(HOLD_CYC - 1);
        end else if (armed[i]) begin
          if (rpt_cnt[i] == 32'd0) rpt_cnt[i] <= 32'(RPT_CYC - 1);
          else                     rpt_cnt[i] <= rpt_cnt[i] - 32'd1;
        end
      end
    end
  end

  assign evt_next = rise | {1'b0, rpt_hit};
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{32'(HOLD_CYC), 32'(RPT_CYC)};
  assign evt_next = rise;
`endif

  // Register events so pointer/RAM updates land one cycle after detection
  always_ff @(posedge clk) begin
    if (rst) ev <= 3'b000;
    else     ev <= evt_next;
  end

  // Decode events; opposing next+prev cancel, write only in edit mode
  always_comb begin
    do_next  = ev[0] & ~ev[1];
    do_prev  = ev[1] & ~ev[0];
    do_wr    = ev[2] & sw_s2;
    addr_ext = {1'b0, address};
    sum      = addr_ext + STEP_P;
    next_addr = ADDR_W'((sum >= DEPTH_P) ? sum - DEPTH_P : sum);
    prev_addr = ADDR_W'((addr_ext < STEP_P) ? addr_ext + DEPTH_P - STEP_P
                                            : addr_ext - STEP_P);
  end

  // Pointer and write acknowledge; write uses the old pointer, then it moves
  always_ff @(posedge clk) begin
    if (rst) begin
      address <= '0;
      wr_ack  <= 1'b0;
    end else begin
      wr_ack <= do_wr;
      if (do_next)      address <= next_addr;
      else if (do_prev) address <= prev_addr;
    end
  end

  // RAM write port; contents survive reset, but a write in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[address] <= wdata;
  end

  // Registered read-first output
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= mem[address];
  end

endmodule

// File: tb/tb_ram_nav_ctrl.sv
// Self-checking bench for ram_nav_ctrl (DEPTH=8, STEP=3): reset checks,
// a table of button presses with hand-derived results, multi-cycle corner
// sequences, and randomized traffic against a behavioural model.
module tb_ram_nav_ctrl;
  localparam int DW = 8, DEPTH = 8, AW = 3, STEP = 3;

  logic          clk = 1'b0;
  logic          rst, switch;
  logic [2:0]    btn;
  logic [DW-1:0] wdata, q;
  logic [AW-1:0] address;
  logic          wr_ack;

  always #5 clk = ~clk;

  ram_nav_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .STEP(STEP),
                 .HOLD_CYC(10), .RPT_CYC(4)) dut (
    .clk(clk), .rst(rst), .switch(switch), .btn(btn), .wdata(wdata),
    .q(q), .address(address), .wr_ack(wr_ack));

  int total = 0, bad = 0;

  // Model: an input sample taken at edge k acts at edge k+3 if it is a rise
  // over the sample at k-1; any reset across that window drops it.
  logic [2:0]    hb [5];
  logic          hs [5];
  logic          hr [5];
  int            m_addr = 0;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_mv [DEPTH];
  logic [DW-1:0] m_q = '0;
  bit            m_qv = 1'b0;
  bit            m_ack = 1'b0;
  bit            model_on = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] b, input logic s, input logic r,
                      input logic [DW-1:0] wd);
    logic [2:0] e;
    logic       wr;
    btn = b; switch = s; rst = r; wdata = wd;
    @(posedge clk);
    for (int i = 4; i > 0; i--) begin
      hb[i] = hb[i-1]; hs[i] = hs[i-1]; hr[i] = hr[i-1];
    end
    hb[0] = b; hs[0] = s; hr[0] = r;
    if (r) begin
      m_addr = 0; m_q = '0; m_qv = 1'b1; m_ack = 1'b0;
    end else begin
      e = (hr[0] | hr[1] | hr[2] | hr[3] | hr[4]) ? 3'b000 : (hb[3] & ~hb[4]);
      wr = e[2] & hs[2];
      m_q  = m_mem[m_addr];
      m_qv = m_mv[m_addr];
      if (wr) begin m_mem[m_addr] = wd; m_mv[m_addr] = 1'b1; end
      m_ack = wr;
      if (e[0] && !e[1])      m_addr = (m_addr + STEP) % DEPTH;
      else if (e[1] && !e[0]) m_addr = (m_addr + DEPTH - STEP) % DEPTH;
    end
    #1;
    if (model_on) begin
      check("model_addr", address, m_addr);
      check("model_ack", wr_ack, m_ack);
      if (m_qv) check("model_q", q, m_q);
    end
  endtask

  task automatic press(input logic [2:0] b, input logic s, input logic [DW-1:0] wd,
                       output int acks);
    acks = 0;
    step(b, s, 1'b0, wd);
    acks += wr_ack;
    for (int j = 0; j < 6; j++) begin
      step(3'b000, s, 1'b0, wd);
      acks += wr_ack;
    end
  endtask

  typedef struct {
    logic [2:0]    b;
    logic          s;
    logic [DW-1:0] wd;
    int            addr;
    int            acks;
    int            qexp;   // -1: word not yet defined, skip
  } vec_t;

  vec_t tbl [13];

  initial begin
    int acks, moves, prev_a, exp_moves;
    tbl[0]  = '{3'b001, 1'b0, 8'h00, 3, 0, -1};
    tbl[1]  = '{3'b001, 1'b0, 8'h00, 6, 0, -1};
    tbl[2]  = '{3'b001, 1'b0, 8'h00, 1, 0, -1};
    tbl[3]  = '{3'b010, 1'b0, 8'h00, 6, 0, -1};
    tbl[4]  = '{3'b010, 1'b0, 8'h00, 3, 0, -1};
    tbl[5]  = '{3'b010, 1'b0, 8'h00, 0, 0, -1};
    tbl[6]  = '{3'b010, 1'b0, 8'h00, 5, 0, -1};
    tbl[7]  = '{3'b100, 1'b1, 8'hA5, 5, 1, 8'hA5};
    tbl[8]  = '{3'b100, 1'b0, 8'h3C, 5, 0, 8'hA5};
    tbl[9]  = '{3'b011, 1'b0, 8'h00, 5, 0, 8'hA5};
    tbl[10] = '{3'b010, 1'b0, 8'h00, 2, 0, -1};
    tbl[11] = '{3'b101, 1'b1, 8'h5A, 5, 1, 8'hA5};
    tbl[12] = '{3'b010, 1'b0, 8'h00, 2, 0, 8'h5A};

    for (int i = 0; i < 5; i++) begin hb[i] = 3'b000; hs[i] = 1'b0; hr[i] = 1'b1; end
    btn = 3'b000; switch = 1'b0; rst = 1'b1; wdata = '0;

    // reset holds all outputs at zero
    for (int i = 0; i < 4; i++) begin
      step(3'b000, 1'b0, 1'b1, 8'h00);
      check("rst_addr", address, 0);
      check("rst_q", q, 0);
      check("rst_ack", wr_ack, 0);
    end
    for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 1'b0, 8'h00);

    // table of presses
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].b, tbl[i].s, tbl[i].wd, acks);
      check($sformatf("tbl%0d_addr", i), address, tbl[i].addr);
      check($sformatf("tbl%0d_acks", i), acks, tbl[i].acks);
      if (tbl[i].qexp >= 0) check($sformatf("tbl%0d_q", i), q, tbl[i].qexp);
    end

    // write latency at address 2: ack exactly after edge N+3, new q after N+4
    for (int j = 0; j < 5; j++) begin
      step(j == 0 ? 3'b100 : 3'b000, 1'b1, 1'b0, 8'h77);
      check($sformatf("lat_ack%0d", j), wr_ack, (j == 3) ? 1 : 0);
      if (j == 3) check("lat_q_old", q, 8'h5A);
      if (j == 4) check("lat_q_new", q, 8'h77);
    end

    // next held through a reset pulse: no event until released and re-pressed
    for (int j = 0; j < 4; j++) step(3'b001, 1'b0, 1'b0, 8'h00);
    check("hold_pre_rst", address, 5);
    step(3'b001, 1'b0, 1'b1, 8'h00);
    for (int j = 0; j < 12; j++) begin
      step(3'b001, 1'b0, 1'b0, 8'h00);
      check("hold_stay0", address, 0);
    end
    step(3'b000, 1'b0, 1'b0, 8'h00);
    step(3'b000, 1'b0, 1'b0, 8'h00);
    press(3'b001, 1'b0, 8'h00, acks);
    check("hold_repress", address, 3);

    // long hold of next: repeats only with auto-repeat built in
    step(3'b000, 1'b0, 1'b1, 8'h00);
    for (int j = 0; j < 3; j++) step(3'b000, 1'b0, 1'b0, 8'h00);
    model_on = 1'b0;
    moves = 0; prev_a = address;
    for (int j = 0; j < 44; j++) begin
      step(j < 32 ? 3'b001 : 3'b000, 1'b0, 1'b0, 8'h00);
      if (address != prev_a) moves++;
      prev_a = address;
    end
`ifdef AUTO_REPEAT_EN
    exp_moves = 7;
`else
    exp_moves = 1;
`endif
    check("repeat_moves", moves, exp_moves);
    check("repeat_addr", address, (exp_moves * STEP) % DEPTH);
    step(3'b000, 1'b0, 1'b1, 8'h00);
    step(3'b000, 1'b0, 1'b1, 8'h00);
    model_on = 1'b1;

    // randomized traffic, holds kept short of the repeat threshold
    begin
      logic [2:0] rb;
      logic       rs;
      rs = 1'b0;
      for (int i = 0; i < 600; i++) begin
        rb = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
        if (i % 8 == 7) rb = 3'b000;
        if ($urandom_range(0, 7) == 0) rs = ~rs;
        step(rb, rs, ($urandom_range(0, 59) == 0), 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
